step_sequencer: RTL and testbench

STEP_SEQUENCER -- requirements
Module: step_sequencer

---
 rtl/seq_pkg.sv | 32 +++
 rtl/tempo_divider.sv | 27 ++
 rtl/step_sequencer.sv | 107 ++++++++++
 tb/tb_step_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared constants, state encoding and step-advance helper
// for the drum step sequencer.
package seq_pkg;

    localparam int NUM_TRACKS = 7;
    localparam int NUM_STEPS  = 16;
    localparam int DIV_W      = 24;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

    // Bit positions of each track in the mixer select mask.
    localparam int BASS_DRUM  = 6;
    localparam int SNARE      = 5;
    localparam int CLOSED_HAT = 4;
    localparam int OPEN_HAT   = 3;
    localparam int CLAP       = 2;
    localparam int TOM1       = 1;
    localparam int TOM2       = 0;

    function automatic logic [3:0] next_step(
        input logic [3:0] cur,
        input logic [3:0] last
    );
        if (cur >= last || cur == 4'(NUM_STEPS - 1))
            return 4'd0;
        return cur + 4'd1;
    endfunction

endpackage

// File: rtl/tempo_divider.sv
// Step-period counter; D is tempo_div clamped to a minimum of 2,
// and tick marks the last cycle of each step.
module tempo_divider #(
    parameter int DIV_W = seq_pkg::DIV_W
) (
    input  logic             CLK,
    input  logic             clear,
    input  logic [DIV_W-1:0] tempo_div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] d_eff;

    assign d_eff = (tempo_div < DIV_W'(2)) ? DIV_W'(2) : tempo_div;

    // >= so a shortened period mid-step fires on the very next cycle.
    assign tick = ~clear & (cnt >= d_eff - DIV_W'(1));

    always_ff @(posedge CLK) begin
        if (clear || tick)
            cnt <= '0;
        else
            cnt <= cnt + DIV_W'(1);
    end

endmodule

// File: rtl/step_sequencer.sv
// Drum pattern sequencer: flop-based pattern grid, run/stop FSM,
// and registered per-step select/trigger masks for the mixer.
module step_sequencer #(
    parameter int NUM_TRACKS = seq_pkg::NUM_TRACKS,
    parameter int NUM_STEPS  = seq_pkg::NUM_STEPS,
    parameter int DIV_W      = seq_pkg::DIV_W
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  run,
    input  logic [DIV_W-1:0]      tempo_div,
    input  logic [3:0]            last_step,
    input  logic [NUM_TRACKS-1:0] mute,
    input  logic                  wr_en,
    input  logic [2:0]            wr_track,
    input  logic [3:0]            wr_step,
    input  logic                  wr_val,
    output logic [NUM_TRACKS-1:0] select,
    output logic [NUM_TRACKS-1:0] trigger,
    output logic [3:0]            step_idx,
    output logic                  poweron
);

    import seq_pkg::*;

    state_t                state;
    state_t                state_next;
    logic                  tick;
    logic                  clear;
    logic                  boundary;
    logic [3:0]            s_next;
    logic [NUM_TRACKS-1:0] sel_next;
    logic [NUM_STEPS-1:0]  pattern [NUM_TRACKS];

    assign clear = Reset | ~run | (state == STOPPED);

    tempo_divider #(
        .DIV_W(DIV_W)
    ) u_div (
        .CLK      (CLK),
        .clear    (clear),
        .tempo_div(tempo_div),
        .tick     (tick)
    );

    always_ff @(posedge CLK) begin
        if (Reset)
            state <= STOPPED;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        boundary   = 1'b0;
        s_next     = 4'd0;
        unique case (state)
            STOPPED: begin
                if (run) begin
                    state_next = RUNNING;
                    boundary   = 1'b1;
                end
            end
            RUNNING: begin
                if (!run) begin
                    state_next = STOPPED;
                end else if (tick) begin
                    boundary = 1'b1;
                    s_next   = next_step(step_idx, last_step);
                end
            end
        endcase
    end

    // Reads the grid before this edge's write lands.
    always_comb begin
        sel_next = '0;
        for (int t = 0; t < NUM_TRACKS; t++)
            sel_next[t] = pattern[t][s_next] & ~mute[t];
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int t = 0; t < NUM_TRACKS; t++)
                pattern[t] <= '0;
        end else if (wr_en && 32'(wr_track) < NUM_TRACKS) begin
            pattern[wr_track][wr_step] <= wr_val;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset || state_next == STOPPED) begin
            select   <= '0;
            trigger  <= '0;
            step_idx <= 4'd0;
            poweron  <= 1'b0;
        end else if (boundary) begin
            select   <= sel_next;
            trigger  <= sel_next;
            step_idx <= s_next;
            poweron  <= 1'b1;
        end else begin
            trigger  <= '0;
        end
    end

endmodule

// File: tb/tb_step_sequencer.sv
// Directed checks of the step sequencer: tempo, wrap, mute,
// write/boundary collision, stop and reset behaviour.
module tb_step_sequencer;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        run;
    logic [23:0] tempo_div;
    logic [3:0]  last_step;
    logic [6:0]  mute;
    logic        wr_en;
    logic [2:0]  wr_track;
    logic [3:0]  wr_step;
    logic        wr_val;
    logic [6:0]  select;
    logic [6:0]  trigger;
    logic [3:0]  step_idx;
    logic        poweron;

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] BD = 7'b1000000;
    localparam logic [6:0] SN = 7'b0100000;
    localparam logic [6:0] CH = 7'b0010000;

    step_sequencer dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .run      (run),
        .tempo_div(tempo_div),
        .last_step(last_step),
        .mute     (mute),
        .wr_en    (wr_en),
        .wr_track (wr_track),
        .wr_step  (wr_step),
        .wr_val   (wr_val),
        .select   (select),
        .trigger  (trigger),
        .step_idx (step_idx),
        .poweron  (poweron)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic write(input logic [2:0] t, input logic [3:0] s);
        wr_en = 1'b1;
        wr_track = t;
        wr_step = s;
        wr_val = 1'b1;
        cyc();
        wr_en = 1'b0;
    endtask

    // Pattern loaded below: bass drum on 0/4/8/12, snare on 1/5.
    function automatic logic [6:0] exp_sel(input int s);
        logic [6:0] v;
        v = '0;
        if (s % 4 == 0) v = v | BD;
        if (s == 1 || s == 5) v = v | SN;
        return v;
    endfunction

    initial begin
        Reset = 1'b1;
        run = 1'b0;
        tempo_div = 24'd4;
        last_step = 4'd15;
        mute = '0;
        wr_en = 1'b0;
        wr_track = '0;
        wr_step = '0;
        wr_val = 1'b0;
        cyc();
        cyc();
        check("rst_select", 32'(select), 32'(0));
        check("rst_trigger", 32'(trigger), 32'(0));
        check("rst_step", 32'(step_idx), 32'(0));
        check("rst_poweron", 32'(poweron), 32'(0));
        Reset = 1'b0;

        write(3'd6, 4'd0);
        write(3'd6, 4'd4);
        write(3'd6, 4'd8);
        write(3'd6, 4'd12);
        write(3'd5, 4'd1);
        write(3'd5, 4'd5);
        write(3'd7, 4'd2);
        cyc();
        check("stopped_idle", 32'(poweron), 32'(0));

        // Run from step 0 at 4 cycles per step through one full wrap.
        run = 1'b1;
        cyc();
        check("start_power", 32'(poweron), 32'(1));
        check("start_step", 32'(step_idx), 32'(0));
        check("start_sel", 32'(select), 32'(BD));
        check("start_trig", 32'(trigger), 32'(BD));
        cyc();
        check("trig_one_cycle", 32'(trigger), 32'(0));
        check("sel_held", 32'(select), 32'(BD));
        cyc();
        cyc();
        for (int k = 1; k <= 16; k++) begin
            if (k > 1) begin
                cyc();
                cyc();
                cyc();
            end
            check("pre_step", 32'(step_idx), 32'((k - 1) % 16));
            check("pre_trig", 32'(trigger), 32'(0));
            cyc();
            check("step", 32'(step_idx), 32'(k % 16));
            check("sel", 32'(select), 32'(exp_sel(k % 16)));
            check("trig", 32'(trigger), 32'(exp_sel(k % 16)));
        end

        // Mute snare mid-step: held until the boundary.
        repeat (4) cyc();
        check("mute_step1", 32'(select), 32'(SN));
        cyc();
        mute = SN;
        cyc();
        check("mute_held", 32'(select), 32'(SN));
        cyc();
        cyc();
        check("mute_step2", 32'(select), 32'(0));
        repeat (4) cyc();
        repeat (4) cyc();
        check("mute_step4", 32'(select), 32'(BD));
        repeat (4) cyc();
        check("mute_step5_idx", 32'(step_idx), 32'(5));
        check("mute_step5_sel", 32'(select), 32'(0));
        check("mute_step5_trig", 32'(trigger), 32'(0));
        mute = '0;

        // Shrink last_step while at step 10.
        repeat (20) cyc();
        check("at_step10", 32'(step_idx), 32'(10));
        cyc();
        last_step = 4'd3;
        repeat (3) cyc();
        check("short_wrap", 32'(step_idx), 32'(0));
        check("short_wrap_sel", 32'(select), 32'(BD));
        for (int k = 1; k <= 4; k++) begin
            repeat (4) cyc();
            check("short_seq", 32'(step_idx), 32'(k % 4));
            check("short_sel", 32'(select), 32'(exp_sel(k % 4)));
        end

        // Write a hat hit on step 2 on the same edge that enters step 2.
        repeat (7) cyc();
        wr_en = 1'b1;
        wr_track = 3'd4;
        wr_step = 4'd2;
        wr_val = 1'b1;
        cyc();
        wr_en = 1'b0;
        check("coll_step", 32'(step_idx), 32'(2));
        check("coll_old", 32'(select), 32'(0));
        check("coll_trig", 32'(trigger), 32'(0));
        repeat (16) cyc();
        check("coll_step2", 32'(step_idx), 32'(2));
        check("coll_new", 32'(select), 32'(CH));
        check("coll_new_trig", 32'(trigger), 32'(CH));

        // Tempo below 2 clamps to 2.
        tempo_div = 24'd0;
        cyc();
        check("div0_hold", 32'(step_idx), 32'(2));
        cyc();
        check("div0_adv", 32'(step_idx), 32'(3));
        cyc();
        cyc();
        check("div0_wrap", 32'(step_idx), 32'(0));
        tempo_div = 24'd1;
        cyc();
        check("div1_hold", 32'(step_idx), 32'(0));
        cyc();
        check("div1_adv", 32'(step_idx), 32'(1));

        // Shorten the period after the counter has passed the new end.
        tempo_div = 24'd8;
        repeat (5) cyc();
        check("long_hold", 32'(step_idx), 32'(1));
        tempo_div = 24'd3;
        cyc();
        check("shrink_now", 32'(step_idx), 32'(2));

        // Stop on the same edge as a boundary.
        tempo_div = 24'd4;
        repeat (3) cyc();
        run = 1'b0;
        cyc();
        check("stop_power", 32'(poweron), 32'(0));
        check("stop_sel", 32'(select), 32'(0));
        check("stop_trig", 32'(trigger), 32'(0));
        check("stop_step", 32'(step_idx), 32'(0));

        run = 1'b1;
        cyc();
        check("restart_power", 32'(poweron), 32'(1));
        check("restart_trig", 32'(trigger), 32'(BD));

        // Reset with run low mid-step, then release with run high.
        cyc();
        Reset = 1'b1;
        run = 1'b0;
        cyc();
        check("rst2_power", 32'(poweron), 32'(0));
        check("rst2_sel", 32'(select), 32'(0));
        check("rst2_trig", 32'(trigger), 32'(0));
        check("rst2_step", 32'(step_idx), 32'(0));
        run = 1'b1;
        cyc();
        check("rst_over_run", 32'(poweron), 32'(0));
        Reset = 1'b0;
        last_step = 4'd15;
        cyc();
        check("rel_power", 32'(poweron), 32'(1));
        check("rel_sel", 32'(select), 32'(0));
        check("rel_trig", 32'(trigger), 32'(0));
        for (int k = 1; k <= 5; k++) begin
            repeat (4) cyc();
            check("cleared_step", 32'(step_idx), 32'(k));
            check("cleared_sel", 32'(select), 32'(0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
